// File: rtl/ram_port_master.sv
// CPU-to-RAM port master: it takes one request at a time, issues the RAM command, waits for
// read data and returns a one-cycle completion. A timeout per phase ends the transaction with an error.
module ram_port_master #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    input  logic              ram_busy,
    input  logic              ram_rd_ready,
    input  logic              ram_rd_ack,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic              ram_rd_en_q, ram_rd_en_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic [CNT_W-1:0]  cnt_inc_c;
    logic              timeout_c;

    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign timeout_c = (cnt_inc_c == CNT_LIMIT);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_rd_en_q   <= 1'b0;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_rd_en_q   <= ram_rd_en_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_data_q   <= resp_data_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        ram_wr_en_d   = ram_wr_en_q;
        ram_rd_en_d   = ram_rd_en_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = resp_err_q;
        resp_data_d   = resp_data_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                // req_ready_q gates acceptance so the cycle right after reset does not take a request
                if (req_valid && req_ready_q) begin
                    ram_addr_d    = req_addr;
                    ram_wr_data_d = req_wdata;
                    ram_wr_en_d   = req_we;
                    ram_rd_en_d   = !req_we;
                    req_ready_d   = 1'b0;
                    cnt_d         = '0;
                    state_d       = ISSUE;
                end
            end

            ISSUE: begin
                if (ram_wr_en_q && !ram_busy) begin
                    ram_wr_en_d  = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (ram_rd_en_q && (!ram_busy || ram_rd_ack)) begin
                    ram_rd_en_d = 1'b0;
                    if (ram_rd_ready) begin
                        resp_data_d  = ram_rd_data;
                        resp_err_d   = 1'b0;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RD;
                    end
                end else if (timeout_c) begin
                    ram_wr_en_d  = 1'b0;
                    ram_rd_en_d  = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            WAIT_RD: begin
                if (ram_rd_ready) begin
                    resp_data_d  = ram_rd_data;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (timeout_c) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            RESP: begin
                resp_err_d  = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_rd_en   = ram_rd_en_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed self-checking bench for ram_port_master (TIMEOUT=8): writes, reads, RAM back-pressure,
// timeout and mid-transaction reset.
module tb_ram_port_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic [23:0] ram_addr;
    logic [15:0] ram_wr_data;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic        ram_busy;
    logic        ram_rd_ready;
    logic        ram_rd_ack;
    logic [15:0] ram_rd_data;

    int n_checks;
    int n_fail;

    ram_port_master #(
        .ADDR_W (24),
        .DATA_W (16),
        .TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_en   (ram_rd_en),
        .ram_busy    (ram_busy),
        .ram_rd_ready(ram_rd_ready),
        .ram_rd_ack  (ram_rd_ack),
        .ram_rd_data (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic we, input logic [23:0] addr, input logic [15:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        ram_busy     = 1'b0;
        ram_rd_ready = 1'b0;
        ram_rd_ack   = 1'b0;
        ram_rd_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Simple write, no back-pressure
        request(1'b1, 24'h000012, 16'hBEEF);
        check("wr_en", 32'(ram_wr_en), 32'd1);
        check("wr_rd_en", 32'(ram_rd_en), 32'd0);
        check("wr_addr", 32'(ram_addr), 32'h12);
        check("wr_data", 32'(ram_wr_data), 32'hBEEF);
        check("wr_req_ready", 32'(req_ready), 32'd0);
        check("wr_resp_early", 32'(resp_valid), 32'd0);
        tick();
        check("wr_en_drop", 32'(ram_wr_en), 32'd0);
        check("wr_resp_valid", 32'(resp_valid), 32'd1);
        check("wr_resp_err", 32'(resp_err), 32'd0);
        check("wr_resp_data", 32'(resp_data), 32'd0);
        tick();
        check("wr_resp_pulse", 32'(resp_valid), 32'd0);
        check("wr_idle_ready", 32'(req_ready), 32'd1);

        // Write held off by ram_busy for 5 cycles; a stray request meanwhile must be ignored
        ram_busy = 1'b1;
        request(1'b1, 24'h000345, 16'hCAFE);
        req_valid = 1'b1;
        req_addr  = 24'h000999;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                ram_busy  = 1'b0;
                req_valid = 1'b0;
            end
            check($sformatf("busy_wr_en_%0d", i), 32'(ram_wr_en), 32'd1);
            check($sformatf("busy_addr_%0d", i), 32'(ram_addr), 32'h345);
            check($sformatf("busy_data_%0d", i), 32'(ram_wr_data), 32'hCAFE);
            tick();
        end
        check("busy_wr_drop", 32'(ram_wr_en), 32'd0);
        check("busy_resp_valid", 32'(resp_valid), 32'd1);
        check("busy_resp_err", 32'(resp_err), 32'd0);
        tick();

        // Read with data two cycles after acceptance
        request(1'b0, 24'h0000A5, 16'h0000);
        check("rd_en", 32'(ram_rd_en), 32'd1);
        check("rd_wr_en", 32'(ram_wr_en), 32'd0);
        check("rd_addr", 32'(ram_addr), 32'hA5);
        tick();
        check("rd_en_drop", 32'(ram_rd_en), 32'd0);
        check("rd_wait_no_resp", 32'(resp_valid), 32'd0);
        tick();
        ram_rd_ready = 1'b1;
        ram_rd_data  = 16'h1234;
        tick();
        ram_rd_ready = 1'b0;
        ram_rd_data  = 16'hFFFF;
        check("rd_resp_valid", 32'(resp_valid), 32'd1);
        check("rd_resp_data", 32'(resp_data), 32'h1234);
        check("rd_resp_err", 32'(resp_err), 32'd0);
        tick();
        check("rd_resp_pulse", 32'(resp_valid), 32'd0);
        check("rd_data_hold", 32'(resp_data), 32'h1234);

        // Read whose data never arrives: times out after 8 WAIT_RD cycles
        request(1'b0, 24'h000077, 16'h0000);
        check("to_rd_en", 32'(ram_rd_en), 32'd1);
        tick();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("to_wait_%0d", i), 32'(resp_valid), 32'd0);
            tick();
        end
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_resp_err", 32'(resp_err), 32'd1);
        check("to_resp_data", 32'(resp_data), 32'd0);
        check("to_rd_en_low", 32'(ram_rd_en), 32'd0);
        tick();

        // Read accepted via ram_rd_ack while busy, data one cycle after acceptance
        ram_busy   = 1'b1;
        ram_rd_ack = 1'b1;
        request(1'b0, 24'h00001C, 16'h0000);
        check("ack_rd_en", 32'(ram_rd_en), 32'd1);
        tick();
        ram_busy     = 1'b0;
        ram_rd_ack   = 1'b0;
        check("ack_rd_en_drop", 32'(ram_rd_en), 32'd0);
        check("ack_no_resp", 32'(resp_valid), 32'd0);
        ram_rd_ready = 1'b1;
        ram_rd_data  = 16'h5A5A;
        tick();
        ram_rd_ready = 1'b0;
        check("ack_resp_valid", 32'(resp_valid), 32'd1);
        check("ack_resp_data", 32'(resp_data), 32'h5A5A);
        check("ack_resp_err", 32'(resp_err), 32'd0);
        tick();

        // Read data returned in the same cycle as acceptance
        request(1'b0, 24'h000002, 16'h0000);
        ram_rd_ready = 1'b1;
        ram_rd_data  = 16'h0F0F;
        tick();
        ram_rd_ready = 1'b0;
        check("same_resp_valid", 32'(resp_valid), 32'd1);
        check("same_resp_data", 32'(resp_data), 32'h0F0F);
        check("same_rd_en", 32'(ram_rd_en), 32'd0);
        tick();

        // Reset during WAIT_RD aborts the read; later ram_rd_ready is ignored
        request(1'b0, 24'h000040, 16'h0000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_rd_en", 32'(ram_rd_en), 32'd0);
        check("abort_wr_en", 32'(ram_wr_en), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_ram_addr", 32'(ram_addr), 32'd0);
        tick();
        rst          = 1'b0;
        ram_rd_ready = 1'b1;
        ram_rd_data  = 16'hDEAD;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("stray_resp_%0d", i), 32'(resp_valid), 32'd0);
            check($sformatf("stray_ready_%0d", i), 32'(req_ready), 32'd1);
        end
        check("stray_resp_data", 32'(resp_data), 32'd0);
        ram_rd_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_master.md
RAM_PORT_MASTER -- requirements
Module: ram_port_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per phase (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  CPU request present.
REQ-007 SHALL have port req_we  input  1  1=write, 0=read.
REQ-008 SHALL have port req_addr  input  ADDR_W  request address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port req_ready  output  1  master can accept a request.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_data  output  DATA_W  read data; 0 for writes and errors.
REQ-013 SHALL have port resp_err  output  1  timeout flag, valid with resp_valid.
REQ-014 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-015 SHALL have port ram_wr_data  output  DATA_W  RAM write data.
REQ-016 SHALL have port ram_wr_en  output  1  write command strobe.
REQ-017 SHALL have port ram_rd_en  output  1  read command strobe.
REQ-018 SHALL have port ram_busy  input  1  RAM cannot accept a command.
REQ-019 SHALL have port ram_rd_ready  input  1  ram_rd_data valid this cycle.
REQ-020 SHALL have port ram_rd_ack  input  1  RAM accepted read command.
REQ-021 SHALL have port ram_rd_data  input  DATA_W  RAM read data.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, RESP; all outputs registered.
REQ-023 IDLE: req_ready=1; on req_valid SHALL latch req_we/req_addr/req_wdata and enter ISSUE next cycle; req_valid ignored outside IDLE.
REQ-024 ISSUE: SHALL hold ram_addr, ram_wr_data and exactly one of ram_wr_en/ram_rd_en high, stable until acceptance.
REQ-025 Write acceptance = ram_busy==0 sampled while ram_wr_en high; read acceptance = (ram_busy==0 or ram_rd_ack==1) while ram_rd_en high.
REQ-026 On acceptance the strobe SHALL deassert next cycle; write -> RESP, read -> WAIT_RD.
REQ-027 Read accepted with ram_rd_ready=1 same cycle SHALL capture ram_rd_data and go directly to RESP.
REQ-028 WAIT_RD: on ram_rd_ready SHALL capture ram_rd_data into resp_data and enter RESP; ram_rd_ready in any other state ignored.
REQ-029 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in ISSUE, WAIT_RD, RESP.
REQ-030 8-bit wait counter SHALL clear on entering ISSUE and WAIT_RD, increment each cycle in them; reaching TIMEOUT SHALL drop strobes, set resp_err=1, resp_data=0, enter RESP.
REQ-031 Minimum latency: write req_valid (IDLE) to resp_valid = 3 cycles; read with ram_rd_ready one cycle after acceptance = 4 cycles.
REQ-032 resp_err SHALL be 0 for every non-timeout completion; resp_data SHALL hold value until next RESP.

Reset
REQ-033 On rst (asynchronous, no clock needed): state=IDLE, req_ready=0 while rst high then 1 first cycle after release, resp_valid=0, resp_err=0, resp_data=0, ram_wr_en=0, ram_rd_en=0, ram_addr=0, ram_wr_data=0, counter=0.
REQ-034 rst mid-transaction SHALL abort it with no resp_valid; a later stray ram_rd_ready SHALL be ignored.

Verification
REQ-035 Write addr 0x000012 data 0xBEEF, ram_busy=0 -> ram_wr_en high one cycle with those values, resp_valid 3 cycles after req, resp_err=0.
REQ-036 Read addr 0x0000A5, ram_rd_ready with 0x1234 two cycles after acceptance -> resp_data=0x1234, resp_valid one cycle, ram_rd_en high one cycle.
REQ-037 ram_busy=1 for 5 cycles during write -> ram_wr_en held 6 cycles, address/data stable, then normal completion.
REQ-038 Read, ram_rd_ready never asserted, TIMEOUT=8 -> resp_valid with resp_err=1, resp_data=0 after 8 WAIT_RD cycles; next request served normally.
REQ-039 Read, ram_rd_ack=1 while ram_busy=1 -> accepted that cycle, ram_rd_en drops next cycle.
REQ-040 rst asserted mid-WAIT_RD -> strobes 0 immediately, no resp_valid; ram_rd_ready after release ignored, req_ready=1.
